// File: rtl/fcc_cmd_arbiter.sv
// Round-robin scheduler sharing one NAND controller command port among NUM_CH fcc channels.
// Define FCC_ARB_STATS_EN to enable the per-channel issued-command counters on o_grant_cnt.
module fcc_cmd_arbiter #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned REQ_W  = 240,
   parameter int unsigned CH_W   = 3
) (
   input  logic                    nand_usr_clk,
   input  logic                    nand_usr_rstn,
   input  logic [NUM_CH-1:0]       i_ch_cmd_valid,
   input  logic [NUM_CH*REQ_W-1:0] i_ch_req,
   output logic [NUM_CH-1:0]       o_ch_cmd_ready,
   input  logic [NUM_CH-1:0]       i_ch_rbuf_ready,
   input  logic [NUM_CH*24-1:0]    i_ch_wdata_avail,
   input  logic                    i_cmd_ready,
   output logic                    o_cmd_valid,
   output logic [REQ_W-1:0]        o_req,
   output logic [CH_W-1:0]         o_grant_ch,
   output logic [NUM_CH*16-1:0]    o_grant_cnt
);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e            state_q;
   logic [CH_W-1:0]   rr_ptr_q;
   logic [CH_W-1:0]   grant_q;
   logic              cmd_valid_q;
   logic [REQ_W-1:0]  req_q;

   logic [NUM_CH-1:0] cand;
   logic [CH_W-1:0]   win_hi, win_lo, win, rr_next;
   logic              found_hi, found_lo, found;

   // A program needs ceil(len/4) buffered words; 25-bit math keeps len+3 from overflowing.
   always_comb begin
      cand = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         unique case (i_ch_req[k*REQ_W +: 2])
            2'b01: cand[k] = i_ch_cmd_valid[k] &&
                             ({1'b0, i_ch_wdata_avail[k*24 +: 24]} >=
                              (({1'b0, i_ch_req[k*REQ_W+80 +: 24]} + 25'd3) >> 2));
            2'b10: cand[k] = i_ch_cmd_valid[k] & i_ch_rbuf_ready[k];
            default: cand[k] = i_ch_cmd_valid[k];
         endcase
      end
   end

   // Lowest candidate at/after rr_ptr wins; otherwise wrap to the lowest candidate overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cand[i]) begin
            found_lo = 1'b1;
            win_lo   = CH_W'(i);
            if (CH_W'(i) >= rr_ptr_q) begin
               found_hi = 1'b1;
               win_hi   = CH_W'(i);
            end
         end
      end
   end

   assign found   = found_hi | found_lo;
   assign win     = found_hi ? win_hi : win_lo;
   assign rr_next = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);

   always_comb begin
      o_ch_cmd_ready = '0;
      if (nand_usr_rstn && (state_q == StIdle) && found) begin
         o_ch_cmd_ready[win] = 1'b1;
      end
   end

   always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
      if (!nand_usr_rstn) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         cmd_valid_q <= 1'b0;
         req_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  req_q       <= i_ch_req[win*REQ_W +: REQ_W];
                  grant_q     <= win;
                  rr_ptr_q    <= rr_next;
                  cmd_valid_q <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               if (i_cmd_ready && cmd_valid_q) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_cmd_valid = cmd_valid_q;
   assign o_req       = req_q;
   assign o_grant_ch  = grant_q;

`ifdef FCC_ARB_STATS_EN
   logic [NUM_CH*16-1:0] cnt_q;

   always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
      if (!nand_usr_rstn) begin
         cnt_q <= '0;
      end else if (cmd_valid_q && i_cmd_ready) begin
         cnt_q[grant_q*16 +: 16] <= cnt_q[grant_q*16 +: 16] + 16'd1;
      end
   end

   assign o_grant_cnt = cnt_q;
`else
   assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fcc_cmd_arbiter.sv
// Directed bench for fcc_cmd_arbiter: an abstract grant/issue model checked every cycle,
// plus hand-computed expectations for the grant order and data-path gating cases.
module tb_fcc_cmd_arbiter;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [3:0]    vld = '0;
   logic [959:0]  req_bus = '0;
   logic [3:0]    rdy;
   logic [3:0]    rbuf = '0;
   logic [95:0]   avail = '0;
   logic          cready = 1'b0;
   logic          cvalid;
   logic [239:0]  oreq;
   logic [2:0]    gch;
   logic [63:0]   gcnt;

   int total = 0;
   int bad = 0;
   logic [3:0] oneshot = '0;
   logic [3:0] took = '0;

   fcc_cmd_arbiter dut (
      .nand_usr_clk     (clk),
      .nand_usr_rstn    (rstn),
      .i_ch_cmd_valid   (vld),
      .i_ch_req         (req_bus),
      .o_ch_cmd_ready   (rdy),
      .i_ch_rbuf_ready  (rbuf),
      .i_ch_wdata_avail (avail),
      .i_cmd_ready      (cready),
      .o_cmd_valid      (cvalid),
      .o_req            (oreq),
      .o_grant_ch       (gch),
      .o_grant_cnt      (gcnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // ---------------- abstract model ----------------
   logic         m_busy = 1'b0;
   int           m_rr = 0;
   int           m_grant = 0;
   logic [239:0] m_req = '0;
   int           m_cnt [4] = '{0, 0, 0, 0};
   int           m_acc [$];
   int           m_done [$];

   function automatic logic [239:0] mk(input logic [15:0] cmd, input logic [23:0] len,
                                       input logic [7:0] tag);
      return {tag, {8{tag}}, {8{~tag}}, len, {6{tag}}, {tag, tag}, cmd};
   endfunction

   function automatic bit eligible(input int k);
      logic [239:0] b;
      int len;
      int words;
      b = req_bus[k*240 +: 240];
      len = int'(b[103:80]);
      words = int'(avail[k*24 +: 24]);
      case (b[1:0])
         2'b01:   return words >= (len + 3) / 4;
         2'b10:   return rbuf[k];
         default: return 1'b1;
      endcase
   endfunction

   function automatic int pick(input int rr);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = (rr + i) % 4;
         if (vld[k] && eligible(k)) return k;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_busy  <= 1'b0;
         m_rr    <= 0;
         m_grant <= 0;
         m_req   <= '0;
         for (int k = 0; k < 4; k++) m_cnt[k] <= 0;
         m_acc.delete();
         m_done.delete();
      end else if (!m_busy) begin
         if (pick(m_rr) >= 0) begin
            m_busy  <= 1'b1;
            m_grant <= pick(m_rr);
            m_rr    <= (pick(m_rr) + 1) % 4;
            m_req   <= req_bus[pick(m_rr)*240 +: 240];
            m_acc.push_back(pick(m_rr));
         end
      end else if (cready) begin
         m_busy <= 1'b0;
         m_done.push_back(m_grant);
`ifdef FCC_ARB_STATS_EN
         m_cnt[m_grant] <= (m_cnt[m_grant] + 1) % 65536;
`endif
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_model();
      logic [3:0]  er;
      logic [63:0] ec;
      int w;
      w = pick(m_rr);
      er = '0;
      if (rstn && !m_busy && w >= 0) er[w] = 1'b1;
      for (int k = 0; k < 4; k++) ec[k*16 +: 16] = 16'(m_cnt[k]);
      chk("model_ch_ready", 256'(rdy), 256'(er));
      chk("model_cmd_valid", 256'(cvalid), 256'(m_busy));
      chk("model_req", 256'(oreq), 256'(m_req));
      chk("model_grant_ch", 256'(gch), 256'(m_grant));
      chk("model_grant_cnt", 256'(gcnt), 256'(ec));
   endtask

   function automatic int acc_at(input int i);
      return (i < m_acc.size()) ? m_acc[i] : -1;
   endfunction

   task automatic half();
      @(negedge clk);
      check_model();
      took = rdy & vld;
   endtask

   task automatic post();
      @(posedge clk);
      #1;
      vld = vld & ~(took & oneshot);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         half();
         post();
      end
   endtask

   task automatic wait_acc(input int n, input string name);
      for (int i = 0; i < 40 && m_acc.size() < n; i++) cyc(1);
      chk(name, 256'(m_acc.size()), 256'(n));
   endtask

   task automatic set_ch(input int k, input logic [15:0] cmd, input logic [23:0] len,
                         input logic [7:0] tag);
      req_bus[k*240 +: 240] = mk(cmd, len, tag);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      vld = '0;
      cready = 1'b0;
      rbuf = '0;
      avail = '0;
      req_bus = '0;
      oneshot = '0;
      cyc(2);
      rstn = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int exp2 [5];
      logic [63:0] exp_cnt;
      exp2 = '{0, 1, 2, 3, 0};

      // 1: single read on ch0, blocked until its page buffer is ready
      do_reset();
      half();
      chk("reset_cmd_valid", 256'(cvalid), 256'(0));
      chk("reset_req", 256'(oreq), 256'(0));
      post();
      cready = 1'b1;
      oneshot = 4'hF;
      set_ch(0, 16'h0002, 24'd16, 8'h11);
      vld = 4'b0001;
      half();
      chk("t1_rbuf_block", 256'(rdy), 256'(0));
      post();
      rbuf = 4'b0001;
      half();
      chk("t1_ready_T0", 256'(rdy), 256'(4'b0001));
      post();
      half();
      chk("t1_valid_T1", 256'(cvalid), 256'(1));
      chk("t1_req_T1", 256'(oreq), 256'(mk(16'h0002, 24'd16, 8'h11)));
      chk("t1_grant_T1", 256'(gch), 256'(0));
      post();
      half();
      chk("t1_valid_T2", 256'(cvalid), 256'(0));
      post();

      // 2: all channels always valid -> strict rotation, one command every 2 cycles
      do_reset();
      cready = 1'b1;
      for (int k = 0; k < 4; k++) set_ch(k, 16'hA5A0 + 16'(k * 4), 24'd8, 8'(8'h20 + k));
      vld = 4'hF;
      cyc(11);
      vld = '0;
      chk("t2_grant_count", 256'(m_acc.size()), 256'(6));
      for (int i = 0; i < 5; i++) chk("t2_grant_order", 256'(acc_at(i)), 256'(exp2[i]));
      cyc(2);

      // 3: program gated by buffered write data, including rounding and len=0
      do_reset();
      cready = 1'b1;
      oneshot = 4'hF;
      set_ch(1, 16'h0001, 24'd4096, 8'h21);
      avail[1*24 +: 24] = 24'd1023;
      set_ch(2, 16'h0000, 24'd0, 8'h22);
      vld = 4'b0110;
      half();
      chk("t3_skip_ch1", 256'(rdy), 256'(4'b0100));
      post();
      cyc(5);
      chk("t3_ch1_held", 256'(m_acc.size()), 256'(1));
      avail[1*24 +: 24] = 24'd1024;
      wait_acc(2, "t3_ch1_wait");
      chk("t3_ch1_granted", 256'(acc_at(1)), 256'(1));
      set_ch(1, 16'h0001, 24'd4097, 8'h31);
      avail[1*24 +: 24] = 24'd1024;
      set_ch(3, 16'h0001, 24'd0, 8'h33);
      avail[3*24 +: 24] = 24'd0;
      vld = 4'b1010;
      wait_acc(3, "t3_len0_wait");
      chk("t3_len0_granted", 256'(acc_at(2)), 256'(3));
      cyc(4);
      chk("t3_round_held", 256'(m_acc.size()), 256'(3));
      avail[1*24 +: 24] = 24'd1025;
      wait_acc(4, "t3_round_wait");
      chk("t3_round_granted", 256'(acc_at(3)), 256'(1));
      cyc(2);

      // 4: controller stalls for 20 cycles; the issued command must not move
      do_reset();
      oneshot = 4'hF;
      set_ch(0, 16'h0000, 24'd0, 8'h41);
      vld = 4'b0001;
      wait_acc(1, "t4_acc");
      set_ch(0, 16'h0002, 24'd7, 8'h4F);
      set_ch(1, 16'h0000, 24'd0, 8'h42);
      vld = 4'b0011;
      rbuf = 4'hF;
      cyc(20);
      half();
      chk("t4_valid_held", 256'(cvalid), 256'(1));
      chk("t4_req_held", 256'(oreq), 256'(mk(16'h0000, 24'd0, 8'h41)));
      post();
      cready = 1'b1;
      half();
      chk("t4_valid_pre_accept", 256'(cvalid), 256'(1));
      post();
      half();
      chk("t4_valid_post_accept", 256'(cvalid), 256'(0));
      chk("t4_done", 256'(m_done.size()), 256'(1));
      post();
      vld = '0;
      cyc(3);

      // 5: reset during ISSUE drops the command and restarts rotation at ch0
      do_reset();
      oneshot = 4'hF;
      set_ch(2, 16'h0000, 24'd0, 8'h52);
      vld = 4'b0100;
      wait_acc(1, "t5_acc");
      cyc(2);
      rstn = 1'b0;
      #1;
      chk("t5_async_drop", 256'(cvalid), 256'(0));
      chk("t5_async_grant", 256'(gch), 256'(0));
      set_ch(0, 16'h0000, 24'd0, 8'h50);
      set_ch(3, 16'h0003, 24'd0, 8'h53);
      vld = 4'b1001;
      cready = 1'b1;
      cyc(2);
      rstn = 1'b1;
      wait_acc(1, "t5_after_reset");
      chk("t5_first_ch0", 256'(acc_at(0)), 256'(0));
      half();
      chk("t5_dut_grant0", 256'(gch), 256'(0));
      chk("t5_dut_req0", 256'(oreq), 256'(mk(16'h0000, 24'd0, 8'h50)));
      post();
      wait_acc(2, "t5_second");
      chk("t5_then_ch3", 256'(acc_at(1)), 256'(3));
      vld = '0;
      cyc(3);

      // 6: three ch2 commands and the statistics counters
      do_reset();
      cready = 1'b1;
      set_ch(2, 16'h0000, 24'd0, 8'h62);
      vld = 4'b0100;
      for (int i = 0; i < 40 && m_done.size() < 3; i++) cyc(1);
      vld = '0;
      chk("t6_done", 256'(m_done.size()), 256'(3));
      cyc(3);
`ifdef FCC_ARB_STATS_EN
      exp_cnt = 64'h0000_0003_0000_0000;
`else
      exp_cnt = 64'h0;
`endif
      half();
      chk("t6_cnt_ch2", 256'(gcnt[47:32]), 256'(exp_cnt[47:32]));
      chk("t6_cnt_all", 256'(gcnt), 256'(exp_cnt));
      post();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
